// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle sequencer and the datapath decode.
// State encoding, supported opcode and ALU operation classes live here.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StWb,
    StFault
  } ctrl_state_e;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned TIMER_W = 8;

  localparam logic [OPC_W-1:0] OP_RTYPE    = 6'd4;
  localparam logic [1:0]       ALUOP_RTYPE = 2'b10;
  localparam logic [1:0]       ALUOP_NONE  = 2'b00;

  // Only the R-format opcode is implemented by the datapath.
  function automatic logic is_supported(input logic [OPC_W-1:0] op);
    return op == OP_RTYPE;
  endfunction

endpackage

// File: rtl/ctrl_perf_cnt.sv
// Wrap-around performance counters: busy cycles and retired R-format instructions.
// Cleared only by reset.
module ctrl_perf_cnt
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             busy,
  input  logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  logic [CNT_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  always_comb begin
    instr_d = instr_q;
    cycle_d = cycle_q;
    if (retire) instr_d = instr_q + CNT_W'(1);
    if (busy)   cycle_d = cycle_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      instr_q <= instr_d;
      cycle_q <= cycle_d;
    end
  end

  assign instr_cnt = instr_q;
  assign cycle_cnt = cycle_q;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: fetch handshake, IR load, decode/execute/write-back strobes.
// Define CTRL_PERF_EN to add the instr_cnt/cycle_cnt performance counter ports.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned IMEM_TIMEOUT = 15
`ifdef CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [OPC_W-1:0] imem_opcode,
  output logic             ir_load,
  output logic             reg_write,
  output logic [1:0]       alu_op,
  output logic             pc_inc,
  output logic             busy,
  output logic             illegal,
  output logic             timeout
`ifdef CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  localparam logic [TIMER_W-1:0] TimeoutLim = TIMER_W'(IMEM_TIMEOUT);

  ctrl_state_e        state_q, state_d;
  logic [OPC_W-1:0]   opcode_q, opcode_d;
  logic [TIMER_W-1:0] timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      timer_q  <= timer_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    timer_d   = timer_q;
    imem_req  = 1'b0;
    reg_write = 1'b0;
    alu_op    = ALUOP_NONE;
    pc_inc    = 1'b0;
    busy      = 1'b0;
    illegal   = 1'b0;
    timeout   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        // An ack on the last allowed wait cycle still wins over the timeout.
        if (imem_ack) begin
          opcode_d = imem_opcode;
          timer_d  = '0;
          state_d  = StDecode;
        end else if (timer_q + TIMER_W'(1) == TimeoutLim) begin
          timer_d = '0;
          state_d = StFault;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      StDecode: begin
        busy = 1'b1;
        if (is_supported(opcode_q)) begin
          state_d = StExec;
        end else begin
          // Unsupported opcode is skipped; this cycle is an instruction boundary.
          illegal = 1'b1;
          pc_inc  = 1'b1;
          state_d = halt ? StIdle : StFetch;
        end
      end
      StExec: begin
        busy    = 1'b1;
        alu_op  = ALUOP_RTYPE;
        state_d = StWb;
      end
      StWb: begin
        busy      = 1'b1;
        alu_op    = ALUOP_RTYPE;
        reg_write = 1'b1;
        pc_inc    = 1'b1;
        state_d   = halt ? StIdle : StFetch;
      end
      StFault: begin
        timeout = 1'b1;
        if (start) state_d = StFetch;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ir_load = imem_req & imem_ack;

`ifdef CTRL_PERF_EN
  ctrl_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .retire   (reg_write),
    .instr_cnt(instr_cnt),
    .cycle_cnt(cycle_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level model predicts event cycles,
// an independent monitor matches observed strobes against the expected-event queue.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  localparam int unsigned T = 15;
  localparam int EvRetire  = 0;
  localparam int EvIllegal = 1;
  localparam int EvFault   = 2;
  localparam int EvStray   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic       imem_ack = 1'b0;
  logic [5:0] imem_opcode = 6'd0;
  logic       imem_req, ir_load, reg_write, pc_inc, busy, illegal, timeout;
  logic [1:0] alu_op;
`ifdef CTRL_PERF_EN
  logic [15:0] instr_cnt, cycle_cnt;
`endif

  int cyc = 0;
  int n_vec = 0;
  int n_miss = 0;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  multicycle_ctrl #(
    .IMEM_TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_opcode(imem_opcode),
    .ir_load    (ir_load),
    .reg_write  (reg_write),
    .alu_op     (alu_op),
    .pc_inc     (pc_inc),
    .busy       (busy),
    .illegal    (illegal),
    .timeout    (timeout)
`ifdef CTRL_PERF_EN
    ,
    .instr_cnt  (instr_cnt),
    .cycle_cnt  (cycle_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // start/halt outside IDLE/FAULT and off-boundary must be ignored; randomize them.
  task automatic noise();
    start = 1'($urandom);
    halt  = 1'($urandom);
    if (!imem_ack) imem_opcode = 6'($urandom);
  endtask

  // From IDLE or FAULT: a few quiet cycles, then a start pulse into FETCH.
  task automatic restart();
    int k;
    k = $urandom_range(0, 2);
    for (int i = 0; i < k; i++) begin
      start = 1'b0;
      halt  = 1'($urandom);
      step();
    end
    start = 1'b1;
    halt  = 1'($urandom);
    step();
    start = 1'b0;
  endtask

  // Entered at the start of a FETCH cycle. w = ack wait cycles, h = halt at the boundary.
  task automatic run_instr(input int w, input logic [5:0] op, input logic h);
    int f;
    f = cyc;
    check("fetch_req", imem_req, 1);
    check("fetch_busy", busy, 1);
    check("fetch_timeout_low", timeout, 0);
    if (w >= T) begin
      push_ev(EvFault, f + T);
      for (int i = 0; i < T; i++) begin
        noise();
        imem_ack = 1'b0;
        step();
      end
      restart();
    end else begin
      for (int i = 0; i < w; i++) begin
        noise();
        imem_ack = 1'b0;
        step();
      end
      noise();
      imem_ack    = 1'b1;
      imem_opcode = op;
      #1;
      check("ir_load_on_ack", ir_load, 1);
      step();
      imem_ack = 1'b0;
      if (op == 6'd4) begin
        noise();
        step();
        noise();
        step();
        noise();
        halt = h;
        push_ev(EvRetire, f + w + 3);
        step();
      end else begin
        noise();
        halt = h;
        push_ev(EvIllegal, f + w + 1);
        step();
      end
      start = 1'b0;
      if (h) begin
        check("halt_idle_busy", busy, 0);
        check("halt_idle_req", imem_req, 0);
        check("halt_idle_alu_op", alu_op, 0);
      end
    end
  endtask

  // Monitor: every strobe event must match the head of the expected queue.
  initial begin
    logic       tprev;
    logic [1:0] aprev;
    int         kind;
    ev_t        e;
    tprev = 1'b0;
    aprev = 2'b00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        tprev = 1'b0;
        aprev = 2'b00;
        continue;
      end
      kind = -1;
      if (reg_write)              kind = EvRetire;
      else if (illegal)           kind = EvIllegal;
      else if (pc_inc)            kind = EvStray;
      else if (timeout && !tprev) kind = EvFault;
      if (kind >= 0) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          check("event_cycle", cyc, e.at);
          if (kind == EvRetire) begin
            check("wb_alu_op", alu_op, 2);
            check("wb_pc_inc", pc_inc, 1);
            check("exec_alu_op", aprev, 2);
          end
          if (kind == EvIllegal) check("illegal_pc_inc", pc_inc, 1);
          if (kind == EvFault) check("fault_busy", busy, 0);
        end
      end
      tprev = timeout;
      aprev = alu_op;
    end
  end

  initial begin
    int         w;
    logic [5:0] op;
    logic       h;

    // Reset with hostile inputs: everything must stay quiet.
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    start    = 1'b1;
    halt     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_req", imem_req, 0);
    check("rst_ir_load", ir_load, 0);
    check("rst_reg_write", reg_write, 0);
    check("rst_pc_inc", pc_inc, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_illegal", illegal, 0);
    check("rst_timeout", timeout, 0);
    imem_ack = 1'b0;
    start    = 1'b0;
    halt     = 1'b0;
    rst_n    = 1'b1;
    step();
    check("idle_busy", busy, 0);
    start = 1'b1;
    halt  = 1'b1;
    step();
    start = 1'b0;

    run_instr(0, 6'd4, 1'b1);
    restart();
    run_instr(0, 6'd9, 1'b0);
    run_instr(T + 3, 6'd4, 1'b0);
    run_instr(T - 1, 6'd4, 1'b0);

    for (int n = 0; n < 50; n++) begin
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(T - 1, T + 1))
                                        : int'($urandom_range(0, 3));
      op = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd4;
      h  = ($urandom_range(0, 3) == 0);
      run_instr(w, op, h);
      if (h && w < T) restart();
    end

    // Reset in EXEC: abort with no write-back strobes afterwards.
    noise();
    imem_ack    = 1'b1;
    imem_opcode = 6'd4;
    step();
    imem_ack = 1'b0;
    step();
    check("exec_alu_op_pre_rst", alu_op, 2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_alu_op", alu_op, 0);
    check("midrst_reg_write", reg_write, 0);
    check("midrst_pc_inc", pc_inc, 0);
    step();
    step();
    rst_n = 1'b1;
    start = 1'b0;
    halt  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_busy", busy, 0);
      check("post_rst_req", imem_req, 0);
    end

`ifdef CTRL_PERF_EN
    rst_n = 1'b0;
    step();
    check("rst_instr_cnt", instr_cnt, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    rst_n = 1'b1;
    start = 1'b1;
    halt  = 1'b0;
    step();
    start = 1'b0;
    run_instr(0, 6'd4, 1'b0);
    run_instr(0, 6'd4, 1'b0);
    run_instr(0, 6'd4, 1'b1);
    check("perf_instr_cnt", instr_cnt, 3);
    check("perf_cycle_cnt", cycle_cnt, 12);
`endif

    repeat (3) step();
    check("events_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
